// File: rtl/dmem_pkg.sv
// Package shared by the data-memory arbiter files.
// Contents: default widths/depth, FSM state encoding and the master id constants.
package dmem_pkg;

    localparam int unsigned DefAw    = 32;
    localparam int unsigned DefDw    = 32;
    localparam int unsigned DefDepth = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;  // CPU load/store stage
    localparam master_id_t M1 = 1'b1;  // debug/DMA loader

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// Signals:
//   m0_*/m1_*  req, we, addr, wdata, lock (requester -> arbiter); ack, err, rdata (arbiter -> requester)
//   mem_*      addr, datain, we (arbiter -> memory); dataout (memory -> arbiter)
//   busy       arbiter FSM not idle
// Modports: master = requester/memory environment side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_lock;
    logic          m0_ack;
    logic          m0_err;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_ack;
    logic          m1_err;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_datain;
    logic          mem_we;
    logic [DW-1:0] mem_dataout;

    logic          busy;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output mem_dataout,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_addr, mem_datain, mem_we, busy
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  mem_dataout,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_addr, mem_datain, mem_we, busy
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick (combinational).
// Ports:
//   req        [1:0] request per master (bit 0 = M0, bit 1 = M1)
//   last_grant       master granted most recently
//   lock_owner [1:0] one-hot lock holder, 0 = none
//   grant            chosen master (meaningful only when req != 0)
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_grant,
    input  logic [1:0] lock_owner,
    output master_id_t grant
);

    always_comb begin
        grant = M0;
        if (req[0] && lock_owner[0]) begin
            grant = M0;
        end else if (req[1] && lock_owner[1]) begin
            grant = M1;
        end else if (req[0] && req[1]) begin
            grant = (last_grant == M0) ? M1 : M0;
        end else if (req[1]) begin
            grant = M1;
        end else begin
            grant = M0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// One access at a time: IDLE -> ACCESS -> RESP -> IDLE, or IDLE -> RESP for a misaligned or
// out-of-range address (no memory access). Round-robin between M0 and M1, one-cycle ack pulse.
// Optional feature macro: DMEM_ARB_LOCK_EN (keep-grant lock); without it the lock inputs are
// ignored and arbitration is pure round-robin.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   dmem_arbiter_if.slave: both requester ports, memory port and busy
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW    = DefAw,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam logic [AW-1:0] MaxAddr = AW'(DEPTH * 4 - 4);

    state_e        state_q, state_d;
    master_id_t    gnt_q;
    master_id_t    last_grant_q;
    logic          we_q;
    logic          err_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] m0_rdata_q, m1_rdata_q;

    logic [1:0]    req;
    logic [1:0]    lock_owner;
    master_id_t    grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_err;

    assign req = {bus.m1_req, bus.m0_req};

    dmem_rr_pick u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .lock_owner (lock_owner),
        .grant      (grant)
    );

    always_comb begin
        sel_we    = (grant == M0) ? bus.m0_we    : bus.m1_we;
        sel_addr  = (grant == M0) ? bus.m0_addr  : bus.m1_addr;
        sel_wdata = (grant == M0) ? bus.m0_wdata : bus.m1_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > MaxAddr);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|req) state_d = sel_err ? StResp : StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            gnt_q        <= M0;
            last_grant_q <= M1;  // M0 wins the first contention after reset
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && |req) begin
                gnt_q        <= grant;
                last_grant_q <= grant;
                we_q         <= sel_we;
                err_q        <= sel_err;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
            end
            if (state_q == StAccess && !we_q) begin
                if (gnt_q == M0) m0_rdata_q <= bus.mem_dataout;
                else             m1_rdata_q <= bus.mem_dataout;
            end
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    logic [1:0] lock_owner_q, lock_owner_d;
    logic       gnt_lock;

    always_comb begin
        lock_owner_d = lock_owner_q;
        gnt_lock     = (gnt_q == M0) ? bus.m0_lock : bus.m1_lock;
        unique case (state_q)
            // An owner that stops requesting while idle gives up the lock.
            StIdle: lock_owner_d = lock_owner_q & req;
            StResp: begin
                if (err_q || !gnt_lock) lock_owner_d = 2'b00;
                else                    lock_owner_d = (gnt_q == M0) ? 2'b01 : 2'b10;
            end
            default: lock_owner_d = lock_owner_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_owner_q <= 2'b00;
        else     lock_owner_q <= lock_owner_d;
    end

    assign lock_owner = lock_owner_q;
`else
    logic unused_lock;
    assign unused_lock = bus.m0_lock ^ bus.m1_lock;
    assign lock_owner  = 2'b00;
`endif

    // Memory port is only driven during ACCESS so reset drops mem_we immediately.
    assign bus.mem_we     = (state_q == StAccess) && we_q;
    assign bus.mem_addr   = (state_q == StAccess) ? addr_q  : '0;
    assign bus.mem_datain = (state_q == StAccess) ? wdata_q : '0;

    assign bus.m0_ack   = (state_q == StResp) && (gnt_q == M0);
    assign bus.m1_ack   = (state_q == StResp) && (gnt_q == M1);
    assign bus.m0_err   = bus.m0_ack && err_q;
    assign bus.m1_err   = bus.m1_ack && err_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus randomized single accesses and
// contention runs, checked against a transaction-level model (word array, per-master read data,
// last-granted master and lock holder). Honours DMEM_ARB_LOCK_EN like the design.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port memory: asynchronous read, synchronous write, plus a backdoor for preload.
    logic [31:0] mem [32];
    logic        bd_we = 1'b0;
    logic [4:0]  bd_idx = 5'd0;
    logic [31:0] bd_data = 32'd0;

    always @(posedge clk) begin
        if (bd_we)           mem[bd_idx] <= bd_data;
        else if (bus.mem_we) mem[bus.mem_addr[6:2]] <= bus.mem_datain;
    end
    assign bus.mem_dataout = mem[bus.mem_addr[6:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [31:0] ref_mem [32];
    logic [31:0] ref_rdata [2];
    int          ref_last;
    int          ref_owner;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > 32'd124);
    endfunction

    function automatic logic get_ack(input int m);
        return (m == 1) ? bus.m1_ack : bus.m0_ack;
    endfunction

    function automatic logic get_err(input int m);
        return (m == 1) ? bus.m1_err : bus.m0_err;
    endfunction

    function automatic logic [31:0] get_rdata(input int m);
        return (m == 1) ? bus.m1_rdata : bus.m0_rdata;
    endfunction

    task automatic drive(input int m, input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] data);
        if (m == 1) begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = data;
        end else begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = data;
        end
    endtask

    // One isolated transfer by master m, checked for latency, memory side effects and response.
    task automatic single(input int m, input bit we, input logic [31:0] addr,
                          input logic [31:0] data);
        bit bad   = addr_bad(addr);
        bit got   = 0;
        bit wseen = 0;
        bit other = 0;
        int lat   = 0;
        drive(m, 1, we, addr, data);
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            lat++;
            if (get_ack(1 - m)) other = 1;
            if (get_ack(m)) begin
                got = 1;
            end else if (bus.busy) begin
                check("access_addr", bus.mem_addr, addr);
                if (bus.mem_we) begin
                    wseen = 1;
                    check("access_wdata", bus.mem_datain, data);
                end
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        check("ack_latency", 32'(lat), bad ? 32'd1 : 32'd2);
        check("mem_we_seen", 32'(wseen), 32'(!bad && we));
        check("other_ack", 32'(other), 32'd0);
        check("err", 32'(get_err(m)), 32'(bad));
        if (!bad && !we) ref_rdata[m] = ref_mem[addr[6:2]];
        if (!bad && we)  ref_mem[addr[6:2]] = data;
        check("rdata_granted", get_rdata(m), ref_rdata[m]);
        check("rdata_other", get_rdata(1 - m), ref_rdata[1 - m]);
        ref_last  = m;
        ref_owner = -1;
        drive(m, 0, 0, 32'd0, 32'd0);
        tick();
        check("idle_after", 32'(bus.busy), 32'd0);
    endtask

    // Both masters keep requesting writes; n acks are collected and checked against the model.
    task automatic contend(input int n, input logic [31:0] a0, input logic [31:0] a1,
                           input bit drop_lock_at3, output logic [7:0] seq);
        logic [31:0] cur_data [2];
        logic [31:0] cur_addr [2];
        int          last_cyc [2];
        int          acks = 0;
        int          m0_acks = 0;
        int          pred;
        bit          lockv;
        seq = 8'd0;
        cur_addr[0] = a0;
        cur_addr[1] = a1;
        for (int m = 0; m < 2; m++) begin
            cur_data[m] = $urandom;
            last_cyc[m] = -1;
            drive(m, 1, 1, cur_addr[m], cur_data[m]);
        end
        for (int c = 0; c < 80 && acks < n; c++) begin
            tick();
            check("single_ack", 32'(bus.m0_ack && bus.m1_ack), 32'd0);
            for (int m = 0; m < 2; m++) begin
                if (get_ack(m)) begin
                    pred = (ref_owner >= 0) ? ref_owner : 1 - ref_last;
                    check("rr_grant", 32'(m), 32'(pred));
                    check("rr_err", 32'(get_err(m)), 32'd0);
                    if (last_cyc[m] >= 0 && ref_owner < 0 && pred != m)
                        check("rr_gap", 32'(cyc - last_cyc[m]), 32'd6);
                    last_cyc[m] = cyc;
                    ref_mem[cur_addr[m][6:2]] = cur_data[m];
                    ref_last = m;
                    seq[acks] = 1'(m);
                    acks++;
                    if (m == 0) m0_acks++;
                    if (drop_lock_at3 && m == 0 && m0_acks == 3) bus.m0_lock = 1'b0;
                    lockv = (m == 1) ? bus.m1_lock : bus.m0_lock;
`ifdef DMEM_ARB_LOCK_EN
                    ref_owner = lockv ? m : -1;
`else
                    ref_owner = -1;
                    lockv = 1'b0;
`endif
                    cur_data[m] = $urandom;
                    drive(m, 1, 1, cur_addr[m], cur_data[m]);
                end
            end
        end
        check("contend_acks", 32'(acks), 32'(n));
        drive(0, 0, 0, 32'd0, 32'd0);
        drive(1, 0, 0, 32'd0, 32'd0);
        tick();
        ref_owner = -1;
        check("rdata0_kept", bus.m0_rdata, ref_rdata[0]);
        check("rdata1_kept", bus.m1_rdata, ref_rdata[1]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  seq;
        logic [31:0] addr;
        logic [31:0] d;
        int          m;
        bit          we;

        drive(0, 0, 0, 32'd0, 32'd0);
        drive(1, 0, 0, 32'd0, 32'd0);
        bus.m0_lock = 1'b0;
        bus.m1_lock = 1'b0;
        ref_rdata[0] = 32'd0;
        ref_rdata[1] = 32'd0;
        ref_last  = 1;
        ref_owner = -1;

        // Preload memory while reset is held.
        for (int i = 0; i < 32; i++) begin
            d = (i == 20) ? 32'h0000_00A3 : $urandom;
            ref_mem[i] = d;
            bd_we = 1'b1; bd_idx = 5'(i); bd_data = d;
            tick();
        end
        bd_we = 1'b0;

        // Reset state.
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_m0_ack", 32'(bus.m0_ack), 32'd0);
        check("rst_m1_ack", 32'(bus.m1_ack), 32'd0);
        check("rst_m0_err", 32'(bus.m0_err), 32'd0);
        check("rst_m1_err", 32'(bus.m1_err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_datain", bus.mem_datain, 32'd0);
        check("rst_m0_rdata", bus.m0_rdata, 32'd0);
        check("rst_m1_rdata", bus.m1_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Reset in the middle of an M0 write to 0x50.
        drive(0, 1, 1, 32'h50, 32'hDEAD_BEEF);
        tick();
        check("t1_mem_we_access", 32'(bus.mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_mem_we_dropped", 32'(bus.mem_we), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd0);
        check("t1_ack", 32'(bus.m0_ack), 32'd0);
        drive(0, 0, 0, 32'd0, 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_no_ack", 32'(bus.m0_ack | bus.m1_ack), 32'd0);
        end
        check("t1_mem_kept", mem[20], 32'h0000_00A3);
        ref_last = 1;

        // M0 read of 0x50.
        single(0, 0, 32'h50, 32'd0);
        check("t2_rdata", bus.m0_rdata, 32'h0000_00A3);

        // M1 misaligned and out-of-range reads.
        single(1, 0, 32'h52, 32'd0);
        single(1, 0, 32'h80, 32'd0);

        // M0 write then read back.
        single(0, 1, 32'h60, 32'h258);
        single(0, 0, 32'h60, 32'd0);
        check("t5_rdata", bus.m0_rdata, 32'h0000_0258);

        // Randomized isolated accesses, legal and illegal addresses.
        for (int k = 0; k < 24; k++) begin
            m    = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 35)) * 32'd4;
            if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(1, 3));
            single(m, we, addr, $urandom);
        end

        // Continuous contention on 0x60/0x64.
        contend(8, 32'h60, 32'h64, 1'b0, seq);

        // Lock: make M1 the last grant so M0 wins first, then M0 holds the lock for three grants.
        single(1, 0, 32'h10, 32'd0);
        bus.m0_lock = 1'b1;
        contend(4, 32'h68, 32'h6C, 1'b1, seq);
        bus.m0_lock = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        check("t6_lock_seq", 32'(seq[3:0]), 32'b1000);
`else
        check("t6_lock_seq", 32'(seq[3:0]), 32'b1010);
`endif

        // Memory contents against the model.
        for (int i = 0; i < 32; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
